// File: rtl/fu_arbiter.sv
// Round-robin arbiter sharing one function unit between NREQ requesters.
// Each operation runs grant -> execute -> respond, with a single operation in flight.
package mycpu_pkg;
   typedef logic [3:0] fs_t;
   localparam fs_t FMOVA = 4'd0;
   localparam fs_t FINCA = 4'd1;
   localparam fs_t FADD  = 4'd2;
   localparam fs_t FSUB  = 4'd3;
   localparam fs_t FAND  = 4'd4;
   localparam fs_t FOR   = 4'd5;
   localparam fs_t FXOR  = 4'd6;
   localparam fs_t FNOTA = 4'd7;
   localparam fs_t FSHL  = 4'd8;
   localparam fs_t FSHR  = 4'd9;
   localparam fs_t FMOVB = 4'd10;
   localparam fs_t FDECA = 4'd11;
   localparam fs_t FASR  = 4'd12;
   localparam fs_t FROL  = 4'd13;
   localparam fs_t FROR  = 4'd14;
   localparam fs_t FCLR  = 4'd15;
endpackage

module fu_arbiter
   import mycpu_pkg::*;
#(
   parameter int DW   = 16,
   parameter int NREQ = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ-1:0][DW-1:0]   req_a,
   input  logic [NREQ-1:0][DW-1:0]   req_b,
   input  fs_t  [NREQ-1:0]           req_fs,
   output logic [NREQ-1:0]           rsp_valid,
   input  logic [NREQ-1:0]           rsp_ready,
   output logic [DW-1:0]             rsp_f,
   output logic [1:0]                rsp_nz,
   output logic [DW-1:0]             fu_a,
   output logic [DW-1:0]             fu_b,
   output fs_t                       fu_fs,
   input  logic [DW-1:0]             fu_f,
   input  logic [1:0]                fu_nz
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, owner, gnt_idx;
   logic            gnt_found;
   logic [PW:0]     cand;
   logic            rsp_done;

   logic [DW-1:0]   op_a_p1, op_b_p1;
   fs_t             op_fs_p1;
   logic [DW-1:0]   res_f_p2;
   logic [1:0]      res_nz_p2;
   logic [NREQ-1:0] vld_p2;

   // Search from ptr upward, wrapping at NREQ, for the first valid requester.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr} + (PW+1)'(k);
         if (cand >= (PW+1)'(NREQ))
            cand = cand - (PW+1)'(NREQ);
         if (!gnt_found && req_valid[cand[PW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == S_IDLE && gnt_found)
         req_ready[gnt_idx] = 1'b1;
   end

   assign rsp_done = (state == S_RESP) && rsp_ready[owner];

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (gnt_found) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_RESP;
         S_RESP:  if (rsp_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         owner     <= '0;
         op_a_p1   <= '0;
         op_b_p1   <= '0;
         op_fs_p1  <= FMOVA;
         res_f_p2  <= '0;
         res_nz_p2 <= 2'b00;
         vld_p2    <= '0;
      end else begin
         case (state)
            // p0 -> p1: latch the granted request's operands and owner
            S_IDLE: begin
               if (gnt_found) begin
                  op_a_p1  <= req_a[gnt_idx];
                  op_b_p1  <= req_b[gnt_idx];
                  op_fs_p1 <= req_fs[gnt_idx];
                  owner    <= gnt_idx;
               end
            end
            // p1 -> p2: latch the FU result and raise the owner's response
            S_EXEC: begin
               res_f_p2      <= fu_f;
               res_nz_p2     <= fu_nz;
               vld_p2        <= '0;
               vld_p2[owner] <= 1'b1;
            end
            S_RESP: begin
               if (rsp_done) begin
                  vld_p2 <= '0;
                  ptr    <= (owner == PW'(NREQ-1)) ? '0 : owner + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign fu_a      = op_a_p1;
   assign fu_b      = op_b_p1;
   assign fu_fs     = op_fs_p1;
   assign rsp_f     = res_f_p2;
   assign rsp_nz    = res_nz_p2;
   assign rsp_valid = vld_p2;

endmodule

// File: tb/tb_fu_arbiter.sv
// Self-checking bench for fu_arbiter: a behavioural FU drives fu_f/fu_nz, and a
// round-robin reference model predicts grants, latency and responses.
module tb_fu_arbiter;
   import mycpu_pkg::*;

   localparam int DW   = 16;
   localparam int NREQ = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0]         req_ready;
   logic [NREQ-1:0][DW-1:0] req_a;
   logic [NREQ-1:0][DW-1:0] req_b;
   fs_t  [NREQ-1:0]         req_fs;
   logic [NREQ-1:0]         rsp_valid;
   logic [NREQ-1:0]         rsp_ready;
   logic [DW-1:0]           rsp_f;
   logic [1:0]              rsp_nz;
   logic [DW-1:0]           fu_a, fu_b, fu_f;
   fs_t                     fu_fs;
   logic [1:0]              fu_nz;

   int n_cmp = 0;
   int n_bad = 0;
   int m_ptr = 0;

   always #5 clk = ~clk;

   fu_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_fs(req_fs),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_f(rsp_f), .rsp_nz(rsp_nz),
      .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs),
      .fu_f(fu_f), .fu_nz(fu_nz)
   );

   // Returns {Z, N, f}
   function automatic logic [17:0] fu_model(input logic [15:0] a, input logic [15:0] b,
                                            input fs_t fs);
      logic [15:0] f;
      case (fs)
         FMOVA:   f = a;
         FINCA:   f = a + 16'd1;
         FADD:    f = a + b;
         FSUB:    f = a - b;
         FAND:    f = a & b;
         FOR:     f = a | b;
         FXOR:    f = a ^ b;
         FNOTA:   f = ~a;
         FSHL:    f = {a[14:0], 1'b0};
         FSHR:    f = {1'b0, a[15:1]};
         FMOVB:   f = b;
         FDECA:   f = a - 16'd1;
         FASR:    f = {a[15], a[15:1]};
         FROL:    f = {a[14:0], a[15]};
         FROR:    f = {a[0], a[15:1]};
         default: f = 16'h0000;
      endcase
      return {(f == 16'h0000), f[15], f};
   endfunction

   assign {fu_nz, fu_f} = fu_model(fu_a, fu_b, fu_fs);

   function automatic int first_from(input logic [NREQ-1:0] mask, input int p);
      for (int k = 0; k < NREQ; k++)
         if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      @(posedge clk); #1;
   endtask

   // Single-requester operation with fixed 2-cycle latency and immediate rsp_ready.
   task automatic one_op(input int r, input logic [15:0] a, input logic [15:0] b,
                         input fs_t fs, input string tag);
      logic [17:0]     exp;
      logic [NREQ-1:0] oh;
      logic [15:0]     ef;
      logic [1:0]      enz;
      oh = '0;
      oh[r] = 1'b1;
      exp = fu_model(a, b, fs);
      req_a[r] = a; req_b[r] = b; req_fs[r] = fs; req_valid = oh;
      @(negedge clk);
      n_cmp++; if (req_ready !== oh) begin n_bad++; $display("FAIL %s ready: got %b want %b", tag, req_ready, oh); end
      n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL %s idle_rsp_valid: got %b want 0", tag, rsp_valid); end
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      n_cmp++; if (fu_a !== a) begin n_bad++; $display("FAIL %s fu_a: got %h want %h", tag, fu_a, a); end
      n_cmp++; if (fu_b !== b) begin n_bad++; $display("FAIL %s fu_b: got %h want %h", tag, fu_b, b); end
      n_cmp++; if (fu_fs !== fs) begin n_bad++; $display("FAIL %s fu_fs: got %h want %h", tag, fu_fs, fs); end
      n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL %s exec_ready: got %b want 0", tag, req_ready); end
      ef = fu_f; enz = fu_nz;
      @(negedge clk);
      n_cmp++; if (rsp_valid !== oh) begin n_bad++; $display("FAIL %s rsp_valid: got %b want %b", tag, rsp_valid, oh); end
      n_cmp++; if (rsp_f !== exp[15:0]) begin n_bad++; $display("FAIL %s rsp_f: got %h want %h", tag, rsp_f, exp[15:0]); end
      n_cmp++; if (rsp_nz !== exp[17:16]) begin n_bad++; $display("FAIL %s rsp_nz: got %b want %b", tag, rsp_nz, exp[17:16]); end
      n_cmp++; if (rsp_f !== ef || rsp_nz !== enz) begin n_bad++; $display("FAIL %s rsp_vs_exec: got %h/%b want %h/%b", tag, rsp_f, rsp_nz, ef, enz); end
      m_ptr = (r + 1) % NREQ;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '0; rsp_ready = '1;
      req_a = '0; req_b = '0; req_fs = '0;
      repeat (2) @(negedge clk);
      n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
      n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      n_cmp++; if (fu_a !== '0 || fu_b !== '0) begin n_bad++; $display("FAIL rst_fu_ab: got %h/%h want 0/0", fu_a, fu_b); end
      n_cmp++; if (fu_fs !== FMOVA) begin n_bad++; $display("FAIL rst_fu_fs: got %h want %h", fu_fs, FMOVA); end
      n_cmp++; if (rsp_f !== '0 || rsp_nz !== 2'b00) begin n_bad++; $display("FAIL rst_rsp: got %h/%b want 0/00", rsp_f, rsp_nz); end
      rst_n = 1'b1;
      m_ptr = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      one_op(0, 16'h8000, 16'h1234, FMOVA, "single");
   endtask

   task automatic test_zero_flag();
      one_op(1, 16'h0000, 16'($urandom), FMOVA, "zero");
   endtask

   task automatic test_round_robin();
      int cnt [NREQ];
      int g, cyc;
      logic [NREQ-1:0] oh;
      do_reset();
      foreach (cnt[i]) cnt[i] = 0;
      req_a[0] = 16'h0001; req_a[1] = 16'h0002;
      req_fs = '0; req_valid = '1;
      for (int n = 0; n < 20; n++) begin
         cyc = 0;
         @(negedge clk);
         while (req_ready === '0 && cyc < 8) begin @(negedge clk); cyc++; end
         if (req_ready === '0) begin
            n_cmp++; n_bad++; $display("FAIL rr_grant_timeout: got none want grant at op %0d", n); break;
         end
         g = first_from(req_valid, m_ptr);
         oh = '0; oh[g] = 1'b1;
         n_cmp++; if (req_ready !== oh) begin n_bad++; $display("FAIL rr_grant: got %b want %b at op %0d", req_ready, oh, n); end
         cnt[g]++;
         cyc = 0;
         @(negedge clk);
         while (rsp_valid === '0 && cyc < 8) begin @(negedge clk); cyc++; end
         n_cmp++; if (rsp_valid !== oh || rsp_f !== req_a[g]) begin
            n_bad++; $display("FAIL rr_rsp: got %b/%h want %b/%h at op %0d", rsp_valid, rsp_f, oh, req_a[g], n);
         end
         m_ptr = (g + 1) % NREQ;
      end
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      n_cmp++; if (cnt[0] !== 10 || cnt[1] !== 10) begin n_bad++; $display("FAIL rr_fairness: got %0d/%0d want 10/10", cnt[0], cnt[1]); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [NREQ-1:0] mask, oh;
      logic [17:0]     exp;
      int g;
      for (int n = 0; n < 12; n++) begin
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int r = 0; r < NREQ; r++) begin
            req_a[r] = 16'($urandom); req_b[r] = 16'($urandom); req_fs[r] = fs_t'($urandom);
         end
         g = first_from(mask, m_ptr);
         oh = '0; oh[g] = 1'b1;
         exp = fu_model(req_a[g], req_b[g], req_fs[g]);
         req_valid = mask;
         @(negedge clk);
         n_cmp++; if (req_ready !== oh) begin n_bad++; $display("FAIL rnd_grant: got %b want %b mask %b", req_ready, oh, mask); end
         @(posedge clk); #1 req_valid = '0;
         @(negedge clk);
         n_cmp++; if (fu_a !== req_a[g] || fu_b !== req_b[g] || fu_fs !== req_fs[g]) begin
            n_bad++; $display("FAIL rnd_fu: got %h/%h/%h want %h/%h/%h", fu_a, fu_b, fu_fs, req_a[g], req_b[g], req_fs[g]);
         end
         @(negedge clk);
         n_cmp++; if (rsp_valid !== oh || rsp_f !== exp[15:0] || rsp_nz !== exp[17:16]) begin
            n_bad++; $display("FAIL rnd_rsp: got %b/%h/%b want %b/%h/%b", rsp_valid, rsp_f, rsp_nz, oh, exp[15:0], exp[17:16]);
         end
         m_ptr = (g + 1) % NREQ;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      logic [17:0] exp0, exp1;
      req_a[0] = 16'($urandom); req_b[0] = 16'($urandom); req_fs[0] = fs_t'($urandom);
      req_a[1] = 16'($urandom); req_b[1] = 16'($urandom); req_fs[1] = fs_t'($urandom);
      exp0 = fu_model(req_a[0], req_b[0], req_fs[0]);
      exp1 = fu_model(req_a[1], req_b[1], req_fs[1]);
      rsp_ready = 2'b10;
      req_valid = 2'b01;
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_grant: got %b want 01", req_ready); end
      @(posedge clk); #1 req_valid = 2'b10;
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++; if (rsp_valid !== 2'b01 || rsp_f !== exp0[15:0] || rsp_nz !== exp0[17:16] || req_ready !== '0) begin
            n_bad++; $display("FAIL bp_hold: got %b/%h/%b/%b want 01/%h/%b/00 cyc %0d", rsp_valid, rsp_f, rsp_nz, req_ready, exp0[15:0], exp0[17:16], c);
         end
      end
      @(posedge clk); #1 rsp_ready = '1;
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL bp_release: got %b want 01", rsp_valid); end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== '0 || req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_next: got %b/%b want 00/10", rsp_valid, req_ready); end
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 2'b10 || rsp_f !== exp1[15:0]) begin n_bad++; $display("FAIL bp_second: got %b/%h want 10/%h", rsp_valid, rsp_f, exp1[15:0]); end
      m_ptr = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      logic [17:0] exp0;
      one_op(0, 16'($urandom), 16'($urandom), FADD, "pre_rst");
      req_a[1] = 16'h5A5A; req_b[1] = 16'h0F0F; req_fs[1] = FXOR;
      req_valid = 2'b10;
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL ar_grant: got %b want 10", req_ready); end
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (fu_a !== '0 || fu_b !== '0 || fu_fs !== FMOVA) begin n_bad++; $display("FAIL ar_fu: got %h/%h/%h want 0/0/%h", fu_a, fu_b, fu_fs, FMOVA); end
      n_cmp++; if (rsp_valid !== '0 || rsp_f !== '0 || rsp_nz !== 2'b00 || req_ready !== '0) begin
         n_bad++; $display("FAIL ar_out: got %b/%h/%b/%b want 0/0/00/0", rsp_valid, rsp_f, rsp_nz, req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL ar_no_rsp: got %b want 0 cyc %0d", rsp_valid, c); end
      end
      @(posedge clk); #1;
      req_a[0] = 16'h1111; req_b[0] = 16'h2222; req_fs[0] = FADD;
      req_a[1] = 16'h3333;
      exp0 = fu_model(req_a[0], req_b[0], req_fs[0]);
      req_valid = '1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL ar_ptr: got %b want 01", req_ready); end
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 2'b01 || rsp_f !== exp0[15:0] || rsp_nz !== exp0[17:16]) begin
         n_bad++; $display("FAIL ar_after: got %b/%h/%b want 01/%h/%b", rsp_valid, rsp_f, rsp_nz, exp0[15:0], exp0[17:16]);
      end
      m_ptr = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_fs_sweep();
      for (int i = 0; i < 16; i++)
         one_op(i % NREQ, 16'($urandom), 16'($urandom), fs_t'(i), "sweep");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_zero_flag();
      test_round_robin();
      test_random();
      test_backpressure();
      test_async_reset();
      test_fs_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fu_arbiter.md
# fu_arbiter

Shares the single 16-bit function unit (FU) between NREQ requesters, e.g. the main execute stage and an address/auxiliary sequencer. Each requester submits an operation (A, B, function select) over a valid/ready handshake. The arbiter grants round-robin, registers the operands and drives the FU for one execute cycle. It then returns the FU result and N/Z flags to the granted requester over a per-requester response handshake. One operation is in flight at a time.

## Interface

Parameters:
- DW, 16, operand/result width
- NREQ, 2, number of requesters (legal 2..4)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  request accepted (one-hot or zero)
- req_a  in  NREQ×DW  operand A per requester
- req_b  in  NREQ×DW  operand B per requester
- req_fs  in  NREQ×fs_t  function select per requester (fs_t from mycpu_pkg)
- rsp_valid  out  NREQ  response valid, one-hot to the owning requester, or zero
- rsp_ready  in  NREQ  response consumed per requester
- rsp_f  out  DW  result, shared, qualified by rsp_valid
- rsp_nz  out  2  flags: [0]=N, [1]=Z, shared, qualified by rsp_valid
- fu_a  out  DW  FU operand A
- fu_b  out  DW  FU operand B
- fu_fs  out  fs_t  FU function select
- fu_f  in  DW  FU result (combinational from fu_a/fu_b/fu_fs)
- fu_nz  in  2  FU flags ([0]=N, [1]=Z)

## Operation

FSM states:
- IDLE: if any req_valid, grant one requester and assert its req_ready combinationally in this cycle. On the edge, capture req_a/req_b/req_fs into op registers and the owner index. Next state EXEC. With no valid requests, stay in IDLE.
- EXEC: fu_a/fu_b/fu_fs are driven from the op registers. On the edge, capture fu_f → res_f and fu_nz → res_nz. Next state RESP.
- RESP: rsp_valid[owner]=1. When rsp_ready[owner]=1, update the pointer and go to IDLE. Otherwise hold.

Arbitration:
- Round-robin pointer ptr (clog2(NREQ) bits), reset 0.
- The grant goes to the first requester with valid set, searching from ptr upward, modulo NREQ.
- After a completed response for owner i, ptr = (i+1) mod NREQ.

Protocol rules:
- req_ready is only ever high in IDLE, and is at most one-hot.
- A requester holds req_valid and its data stable until it sees ready; the arbiter does not check this.
- rsp_valid, once high, stays high with rsp_f/rsp_nz stable until the owner's rsp_ready.
- rsp_ready from non-owners is ignored.

FU drive:
- fu_a/fu_b/fu_fs always come from the op registers and hold their last values outside EXEC.
- Result width is DW, taken straight from the FU. No extension or truncation.

Reset values:
- state=IDLE, ptr=0.
- op_a=0, op_b=0, op_fs=FMOVA.
- res_f=0, res_nz=2'b00.
- req_ready=0, rsp_valid=0.
- fu_a=0, fu_b=0, fu_fs=FMOVA.

Boundary conditions:
- Simultaneous requests: ptr decides; the loser waits in IDLE for the next pass.
- Reset asserted mid-EXEC/RESP: the in-flight op is discarded and outputs return to reset values asynchronously. No response is ever delivered for it.
- req_valid dropped while not granted: no effect.

## Timing

- Cycle 0 (IDLE, valid & grant): req_ready high, operands captured at the end of the cycle.
- Cycle 1 (EXEC): FU evaluates.
- Cycle 2 onward (RESP): rsp_valid high.
- Request-to-response latency is 2 cycles. Minimum issue interval is 3 cycles (IDLE→EXEC→RESP with immediate rsp_ready).
- req_ready depends combinationally on req_valid and ptr. All other outputs are registered.

## Test plan

- Reset and single op: after rst_n rises, req 0 sends a=16'h8000, b=16'h1234, fs=FMOVA. Expect req_ready[0] in cycle 0, rsp_valid[0] in cycle 2 with rsp_f=16'h8000, rsp_nz=2'b01, fu_fs=FMOVA during cycle 1.
- Zero flag: req 1 sends FMOVA with a=16'h0000. Expect rsp_valid[1], rsp_f=0, rsp_nz=2'b10, and rsp_valid[0]=0 throughout.
- Round-robin: both requesters hold valid continuously from reset, each with distinct a (16'h0001 and 16'h0002). Grants alternate 0,1,0,1 and each response returns its own a. No requester is starved over 20 ops.
- Response backpressure: hold rsp_ready[0]=0 for 5 cycles in RESP. rsp_valid[0], rsp_f and rsp_nz stay stable, req_ready stays 0 for both, and rsp_ready[1]=1 has no effect.
- Async reset mid-op: assert rst_n=0 during EXEC. Outputs go to reset values immediately, with no rsp_valid after release. The next request (from req 0, ptr=0) completes normally.
- Full fs sweep: for each of the 16 fs_t codes with random a/b, issued through alternating requesters, fu_a/fu_b/fu_fs in EXEC match the submitted values. rsp_f/rsp_nz equal the fu_f/fu_nz sampled in EXEC.
